// File: rtl/riscv_mem_pkg.sv
// Shared state encoding, size/requester codes and lane helpers for the
// RISC-V fetch/load-store memory arbiter.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic ID_FETCH = 1'b0;
    localparam logic ID_LSU   = 1'b1;

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 32'h0000_00ff;
            SZ_HALF: return 32'h0000_ffff;
            default: return 32'hffff_ffff;
        endcase
    endfunction

    // Store data is right-justified; copy it into every lane it could land on.
    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Memory-side bus of the arbiter: master = arbiter, slave = memory.
interface riscv_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/riscv_mem_align.sv
// Byte-enable, alignment check and read-lane shift for one access.
module riscv_mem_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] offset,
    output logic [3:0] be,
    output logic       misaligned,
    output logic [4:0] shamt
);

    always_comb begin
        be         = 4'b0000;
        misaligned = 1'b0;
        shamt      = {offset, 3'b000};
        case (size)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: begin
                be         = 4'b0011 << offset;
                misaligned = offset[0];
            end
            SZ_WORD: begin
                be         = 4'b1111;
                misaligned = |offset;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding arbiter between instruction fetch and load/store onto one
// memory port. Define RISCV_MEM_ARB_RR_EN for round-robin, else LSU priority.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    riscv_mem_arbiter_if.master mem
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              grant;
    logic              expire;
    logic              sel_ls;

    logic              c_we;
    logic [1:0]        c_size;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic [3:0]        c_be;
    logic              c_mis;
    logic [4:0]        c_shamt;

    logic              id_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [4:0]        shamt_q;
    logic              err_q;
    logic [31:0]       rdata_q;

`ifdef RISCV_MEM_ARB_RR_EN
    logic last_ls;

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_ls <= ID_FETCH;
        else if (grant)
            last_ls <= sel_ls;
    end

    assign sel_ls = ls_req & (~if_req | ~last_ls);
`else
    assign sel_ls = ls_req;
`endif

    // Fields of whichever requester wins; a fetch is always a word read.
    assign c_we    = sel_ls ? ls_we    : 1'b0;
    assign c_size  = sel_ls ? ls_size  : SZ_WORD;
    assign c_addr  = sel_ls ? ls_addr  : if_addr;
    assign c_wdata = sel_ls ? ls_wdata : 32'h0;

    riscv_mem_align u_align (
        .size       (c_size),
        .offset     (c_addr[1:0]),
        .be         (c_be),
        .misaligned (c_mis),
        .shamt      (c_shamt)
    );

    assign expire = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (if_req || ls_req)) begin
                    grant     = 1'b1;
                    if_gnt    = ~sel_ls;
                    ls_gnt    = sel_ls;
                    state_nxt = c_mis ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_ack || expire)
                    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (grant)
            wait_cnt <= '0;
        else if (state == WAIT)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Transaction registers need no reset: every output is gated by state.
    always_ff @(posedge clk) begin
        if (grant) begin
            id_q    <= sel_ls;
            we_q    <= c_we;
            size_q  <= c_size;
            be_q    <= c_be;
            addr_q  <= {c_addr[ADDR_W-1:2], 2'b00};
            wdata_q <= lane_replicate(c_size, c_wdata);
            shamt_q <= c_shamt;
            err_q   <= c_mis;
            rdata_q <= 32'h0;
        end else if (state == WAIT) begin
            if (mem.mem_ack) begin
                if (!we_q)
                    rdata_q <= (mem.mem_rdata >> shamt_q) & size_mask(size_q);
            end else if (expire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem.mem_req   = (state == WAIT);
    assign mem.mem_we    = (state == WAIT) & we_q;
    assign mem.mem_be    = (state == WAIT) ? be_q    : 4'b0000;
    assign mem.mem_addr  = (state == WAIT) ? addr_q  : '0;
    assign mem.mem_wdata = (state == WAIT) ? wdata_q : 32'h0;

    assign rsp_valid = (state == RESP);
    assign rsp_id    = (state == RESP) & id_q;
    assign rsp_err   = (state == RESP) & err_q;
    assign rsp_rdata = (state == RESP) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed + randomized bench for riscv_mem_arbiter against a byte-lane model.
module tb_riscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    riscv_mem_arbiter_if #(.ADDR_W(32)) mem_if ();

    riscv_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_size   (ls_size),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

`ifdef RISCV_MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    int   checks = 0;
    int   errors = 0;
    logic last_ls_m = 1'b0;

    typedef struct {
        logic        err;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    // Expected bus view of one access, built lane by lane from the size rules.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] memw);
        exp_t e;
        int   nb;
        int   off;
        off     = int'(addr[1:0]);
        nb      = (size == 2'd3) ? 0 : (1 << size);
        e.be    = 4'b0;
        e.wdata = 32'h0;
        e.rdata = 32'h0;
        if (nb == 0) e.err = 1'b1;
        else         e.err = (off % nb) != 0;
        if (!e.err) begin
            for (int i = 0; i < 4; i++) begin
                e.be[i] = (i >= off) && (i < off + nb);
                e.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
            end
            if (!we)
                for (int i = 0; i < nb; i++)
                    e.rdata[8*i +: 8] = memw[8*(off + i) +: 8];
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_if(input logic [31:0] a);
        if_req  = 1'b1;
        if_addr = a;
    endtask

    task automatic set_ls(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        ls_req   = 1'b1;
        ls_we    = we;
        ls_size  = sz;
        ls_addr  = a;
        ls_wdata = wd;
    endtask

    // Called at a falling edge in IDLE with requests already driven. Runs one
    // grant through its response and returns at the next falling edge (IDLE).
    task automatic serve_one(input int ack_delay, input logic [31:0] memw);
        logic        exp_ls;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        bit          acked;
        exp_t        e;
        #1;
        exp_ls = ls_req && (!if_req || !RR_EN || !last_ls_m);
        check("if_gnt", {31'b0, if_gnt}, {31'b0, !exp_ls});
        check("ls_gnt", {31'b0, ls_gnt}, {31'b0, exp_ls});
        if (exp_ls) begin
            we = ls_we; sz = ls_size; a = ls_addr; wd = ls_wdata;
        end else begin
            we = 1'b0; sz = 2'b10; a = if_addr; wd = 32'h0;
        end
        last_ls_m = exp_ls;
        e = model(we, sz, a, wd, memw);
        @(negedge clk);
        if (exp_ls) ls_req = 1'b0;
        else        if_req = 1'b0;
        acked = 1'b0;
        if (!e.err) begin
            for (int c = 0; c < 16 && !acked; c++) begin
                #1;
                check("mem_req_wait", {31'b0, mem_if.mem_req}, 32'd1);
                check("no_gnt_wait", {30'b0, if_gnt, ls_gnt}, 32'd0);
                if (c == 0) begin
                    check("mem_be", {28'b0, mem_if.mem_be}, {28'b0, e.be});
                    check("mem_addr", mem_if.mem_addr, a & ~32'h3);
                    check("mem_we", {31'b0, mem_if.mem_we}, {31'b0, we});
                    if (we) check("mem_wdata", mem_if.mem_wdata, e.wdata);
                end
                if (c == ack_delay) begin
                    mem_if.mem_ack   = 1'b1;
                    mem_if.mem_rdata = memw;
                    acked = 1'b1;
                end
                @(negedge clk);
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = $urandom;
            end
        end
        #1;
        check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("rsp_id", {31'b0, rsp_id}, {31'b0, exp_ls});
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err || !acked});
        check("rsp_rdata", rsp_rdata, acked ? e.rdata : 32'h0);
        check("mem_req_resp", {31'b0, mem_if.mem_req}, 32'd0);
        check("no_gnt_resp", {30'b0, if_gnt, ls_gnt}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          pick;
        int          d;
        logic [1:0]  sz;

        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h20; ls_wdata = 32'h1234_5678;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
        check("rst_ls_gnt", {31'b0, ls_gnt}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_id", {31'b0, rsp_id}, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_if.mem_we}, 32'd0);
        check("rst_mem_be", {28'b0, mem_if.mem_be}, 32'd0);
        check("rst_mem_addr", mem_if.mem_addr, 32'h0);
        check("rst_mem_wdata", mem_if.mem_wdata, 32'h0);
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0; rst_n = 1'b1;
        last_ls_m = 1'b0;
        @(negedge clk);

        // Simultaneous pair: LSU first, fetch in the IDLE following the LSU response.
        set_if(32'h0000_0100);
        set_ls(1'b0, 2'b10, 32'h0000_0200, 32'h0);
        serve_one(0, 32'h1111_2222);
        serve_one(1, 32'h3333_4444);

        // Four back-to-back grants with both requesters always pending.
        for (int g = 0; g < 4; g++) begin
            if (!if_req) set_if({$urandom_range(0, 255), 2'b00});
            if (!ls_req) set_ls(1'($urandom_range(0, 1)), 2'b10, {$urandom_range(0, 255), 2'b00}, $urandom);
            serve_one($urandom_range(0, 2), $urandom);
        end
        for (int k = 0; k < 2; k++)
            if (if_req || ls_req) serve_one(0, $urandom);

        set_ls(1'b0, 2'b00, 32'h0000_0103, 32'h0);
        serve_one(0, 32'hAABB_CCDD);

        set_ls(1'b1, 2'b10, 32'h0000_0102, 32'hDEAD_BEEF);
        serve_one(0, 32'h0);

        set_ls(1'b0, 2'b11, 32'h0000_0104, 32'h0);
        serve_one(0, 32'h0);

        set_ls(1'b0, 2'b01, 32'h0000_0101, 32'h0);
        serve_one(0, 32'h0);

        set_ls(1'b1, 2'b01, 32'h0000_0106, 32'h0000_BEEF);
        serve_one(2, 32'h0);

        set_if(32'h0000_0203);
        serve_one(0, 32'h0);

        // Ack withheld: timeout, then a stray ack in IDLE must be ignored.
        set_ls(1'b0, 2'b10, 32'h0000_0300, 32'h0);
        serve_one(99, 32'h5555_5555);
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h7777_7777;
        #1;
        check("stray_ack_rsp", {31'b0, rsp_valid}, 32'd0);
        check("stray_ack_mreq", {31'b0, mem_if.mem_req}, 32'd0);
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        #1;
        check("stray_ack_rsp2", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        set_if(32'h0000_0040);
        serve_one(1, 32'h1234_5678);

        // Ack arriving on the last permitted WAIT cycle beats the timeout.
        set_ls(1'b0, 2'b01, 32'h0000_0302, 32'h0);
        serve_one(15, 32'hDEAD_BEEF);

        // Reset in WAIT abandons the access.
        set_if(32'h0000_0080);
        #1;
        check("rstw_gnt", {31'b0, if_gnt}, 32'd1);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check("rstw_mem_req_before", {31'b0, mem_if.mem_req}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("rstw_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
        check("rstw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        last_ls_m = 1'b0;
        @(negedge clk);
        #1;
        check("rstw_rsp_valid2", {31'b0, rsp_valid}, 32'd0);
        check("rstw_mem_req2", {31'b0, mem_if.mem_req}, 32'd0);
        @(negedge clk);
        set_if(32'h0000_0084);
        serve_one(0, 32'hCAFE_F00D);

        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 2);
            if (pick != 1)
                set_if(($urandom_range(0, 7) == 0) ? $urandom : {$urandom_range(0, 1023), 2'b00});
            if (pick != 0) begin
                sz = 2'($urandom_range(0, 3));
                set_ls(1'($urandom_range(0, 1)), sz, $urandom, $urandom);
            end
            for (int k = 0; k < 2; k++) begin
                if (if_req || ls_req) begin
                    d = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
                    serve_one(d, $urandom);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
